// File: rtl/prbs_ber_checker.sv
// prbs_ber_checker: self-synchronising PRBS7/15/21/23/31 bit-error checker.
// Locks onto the recovered stream, tracks lock loss, counts bits and errors.
// Ports:
//   clk, rstb      recovered bit clock, async active-low reset
//   en, clr        checker enable, sync clear of bit_cnt/err_cnt/done
//   prbs_sel[2:0]  0..4 = PRBS7/15/21/23/31, 5..7 invalid
//   in             recovered data bit
//   locked, err    in LOCKED, registered per-error pulse
//   bit_cnt        bits compared while locked (saturating)
//   err_cnt        errors while locked (saturating)
//   done           measurement window complete (sticky)
module prbs_ber_checker #(
  parameter int CNT_W       = 32,
  parameter int SYNC_BITS   = 64,
  parameter int LOSS_WIN    = 256,
  parameter int LOSS_ERR    = 8,
  parameter int WINDOW_BITS = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       prbs_sel,
  input  logic             in,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             done
);

  localparam int MW = $clog2(SYNC_BITS + 1);
  localparam int WW = $clog2(LOSS_WIN + 1);
  localparam int LW = $clog2(LOSS_ERR + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t           r_state;
  logic [30:0]      r_s;
  logic [2:0]       r_sel;
  logic [4:0]       r_seed;
  logic [MW-1:0]    r_match;
  logic [WW-1:0]    r_win;
  logic [LW-1:0]    r_loss;
  logic             r_err;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_done;

  logic             w_sel_ok;
  logic [4:0]       w_oi;
  logic [4:0]       w_ti;
  logic             w_p;
  logic             w_mis;
  logic             w_chg;
  logic             w_cmp;
  logic             w_b;
  logic [CNT_W-1:0] w_bit_nxt;

  // Order/tap bit indices (O-1, T-1) for the selected polynomial.
  always_comb begin
    w_sel_ok = 1'b1;
    w_oi     = 5'd6;
    w_ti     = 5'd5;
    unique case (prbs_sel)
      3'd0: begin w_oi = 5'd6;  w_ti = 5'd5;  end
      3'd1: begin w_oi = 5'd14; w_ti = 5'd13; end
      3'd2: begin w_oi = 5'd20; w_ti = 5'd18; end
      3'd3: begin w_oi = 5'd22; w_ti = 5'd17; end
      3'd4: begin w_oi = 5'd30; w_ti = 5'd27; end
      default: w_sel_ok = 1'b0;
    endcase
  end

  assign w_p   = r_s[w_oi] ^ r_s[w_ti];
  assign w_mis = in ^ w_p;
  assign w_chg = prbs_sel != r_sel;
  assign w_cmp = en && w_sel_ok && !w_chg
              && (r_state == S_LOCKED);
  // Load from the line until locked, then free-run on the prediction.
  assign w_b   = (r_state == S_LOCKED) ? w_p : in;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_sel   <= '0;
      r_seed  <= '0;
      r_match <= '0;
      r_win   <= '0;
      r_loss  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sel <= prbs_sel;
      r_err <= 1'b0;
      if (!en || !w_sel_ok) begin
        r_state <= S_IDLE;
      end else if (r_state == S_IDLE) begin
        r_state <= S_SEED;
        r_seed  <= '0;
      end else begin
        r_s <= {r_s[29:0], w_b};
        if (w_chg) begin
          r_state <= S_SEED;
          r_seed  <= '0;
        end else begin
          unique case (r_state)
            S_SEED: begin
              if (r_seed == w_oi) begin
                r_state <= S_VERIFY;
                r_match <= '0;
              end else begin
                r_seed <= r_seed + 5'd1;
              end
            end
            S_VERIFY: begin
              if (w_mis) begin
                r_state <= S_SEED;
                r_seed  <= '0;
              end else if (r_match == MW'(SYNC_BITS - 1)) begin
                r_state <= S_LOCKED;
                r_win   <= '0;
                r_loss  <= '0;
              end else begin
                r_match <= r_match + MW'(1);
              end
            end
            S_LOCKED: begin
              r_err <= w_mis;
              // An error on the closing bit still counts for that window.
              if (w_mis && r_loss == LW'(LOSS_ERR - 1)) begin
                r_state <= S_SEED;
                r_seed  <= '0;
              end else if (r_win == WW'(LOSS_WIN - 1)) begin
                r_win  <= '0;
                r_loss <= '0;
              end else begin
                r_win  <= r_win + WW'(1);
                r_loss <= r_loss + LW'(w_mis);
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign w_bit_nxt = (&r_bit_cnt) ? r_bit_cnt
                                  : r_bit_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
      r_done    <= 1'b0;
    end else if (clr) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
      r_done    <= 1'b0;
    end else if (w_cmp && !r_done) begin
      r_bit_cnt <= w_bit_nxt;
      if (w_mis && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (WINDOW_BITS != 0
          && w_bit_nxt == CNT_W'(WINDOW_BITS))
        r_done <= 1'b1;
    end
  end

  assign locked  = (r_state == S_LOCKED);
  assign err     = r_err;
  assign bit_cnt = r_bit_cnt;
  assign err_cnt = r_err_cnt;
  assign done    = r_done;

endmodule

// File: doc/prbs_ber_checker.md
# prbs_ber_checker

- Receive-side PRBS bit-error-rate checker for the SERDES link bench.
- Succeeds the fixed-order prbs21 generator: the pattern order is runtime-selectable (PRBS7/15/21/23/31), and it self-synchronises to the recovered data stream, tracks lock, and counts bit errors over a programmable window.
- Sits after the CDR: `in` takes the recovered data and `clk` takes the recovered clock.
- Pure digital; no pwl ports.

## Interface
Parameters:
- CNT_W, 32: width of `bit_cnt` and `err_cnt`.
- SYNC_BITS, 64: consecutive matching bits required to declare lock.
- LOSS_WIN, 256: lock-loss observation window, in compared bits.
- LOSS_ERR, 8: errors within one LOSS_WIN window that drop lock.
- WINDOW_BITS, 0: measurement length in bits; 0 means free-running, with no `done`.

Ports:
- clk  in  1  bit clock; `in` is sampled on the rising edge.
- rstb  in  1  asynchronous, active-low reset.
- en  in  1  checker enable; 0 forces IDLE.
- clr  in  1  synchronous clear of `bit_cnt`, `err_cnt` and `done`.
- prbs_sel  in  3  pattern select: 0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1), 2=PRBS21 (x^21+x^19+1), 3=PRBS23 (x^23+x^18+1), 4=PRBS31 (x^31+x^28+1); codes 5-7 are invalid.
- in  in  1  received data bit.
- locked  out  1  checker is in LOCKED.
- err  out  1  one-cycle pulse per mismatched bit while LOCKED.
- bit_cnt  out  CNT_W  bits compared while LOCKED.
- err_cnt  out  CNT_W  errors while LOCKED.
- done  out  1  measurement window complete; sticky.

## Operation
- Shift register `s[30:0]`.
  - Predicted bit: p = s[O-1] ^ s[T-1], where O is the order and T the tap of the selected polynomial.
  - Each cycle in a non-IDLE state: s <= {s[29:0], b}.
  - b = `in` in SEED and VERIFY (self-synchronising load); b = p in LOCKED (free-running).
- States:
  - IDLE: no activity. Left for SEED when en=1 and prbs_sel is valid.
  - SEED: loads O bits, tracked by seed counter 0..O-1. After the O-th bit, goes to VERIFY and clears the match counter.
  - VERIFY: compares `in` with p.
    - Match: match counter +1. When the count reaches SYNC_BITS, goes to LOCKED and clears the window/loss counters.
    - Mismatch: returns to SEED with the seed counter cleared.
  - LOCKED: compares `in` with p every cycle.
    - Mismatch: err=1 next cycle, and the loss counter +1.
    - Every compared bit advances the window counter. When it reaches LOSS_WIN, both the window and loss counters clear.
    - If the loss counter reaches LOSS_ERR, goes to SEED; `locked` falls the same cycle the state changes.
- Counters:
  - `bit_cnt` and `err_cnt` increment only in LOCKED with done=0.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - If WINDOW_BITS≠0 and `bit_cnt` reaches WINDOW_BITS, done=1 and both counters freeze. Lock tracking continues.
  - Counters are not cleared by lock loss; they accumulate across relocks.
- `clr`:
  - Clears `bit_cnt`, `err_cnt` and `done` only; it does not change the state.
  - clr has priority over a same-cycle increment.
- `prbs_sel` change while en=1: state goes to SEED next cycle; counters are kept.
- Invalid `prbs_sel`: state goes to IDLE, with `locked` and `err` at 0.
- en=0: state goes to IDLE next edge; counters and `done` hold.

## Timing
- Reset (rstb=0, asynchronous): state=IDLE, s=0, all internal counters 0, locked=0, err=0, bit_cnt=0, err_cnt=0, done=0.
- Release of rstb is taken on the next rising edge.
- `err` is registered: it pulses on the cycle after the mismatched bit is sampled.
- `err_cnt` updates on the same edge that `err` rises.
- Lock latency from en rise with a clean stream: 1 (IDLE→SEED) + O (seed) + SYNC_BITS cycles. `locked` rises on the edge after the SYNC_BITS-th match.
  - PRBS7 with defaults: `locked`=1 at edge 72 after en is sampled high.
- `bit_cnt` first increments on the first compared bit after `locked`=1.
- Simultaneous bit error and window boundary: the error counts toward the window that is closing. Lock drops if that brings the loss count to LOSS_ERR.
- Simultaneous `done` threshold and error: the final bit's error is counted, then the counters freeze.

## Test plan
- PRBS7, clean stream, defaults:
  - en at cycle 0 → locked=1 at cycle 72.
  - After 10000 bits: bit_cnt=10000, err_cnt=0, err never pulses.
- PRBS31 locked, bench flips 3 isolated bits spaced 1000 apart:
  - Three single-cycle err pulses, each 1 cycle after its flipped bit; err_cnt=3; locked stays 1.
- PRBS15 locked, burst of 8 flips inside one 256-bit window:
  - locked falls after the 8th error; state passes through SEED and VERIFY; relock after 15+64 clean bits; err_cnt=8.
- WINDOW_BITS=1000, PRBS23:
  - done=1 when bit_cnt=1000; bit_cnt and err_cnt hold while the stream continues.
  - clr pulse → bit_cnt=0, err_cnt=0, done=0, locked stays 1.
- Mode and reset edge cases:
  - prbs_sel 2→0 while locked → locked=0 next cycle, then relock on the PRBS7 stream.
  - prbs_sel=6 → IDLE, locked=0.
  - rstb pulsed low mid-count → all outputs 0 immediately, without waiting for a clock edge.
- Saturation with CNT_W=4, all-error stream after lock (LOSS_ERR large):
  - err_cnt stops at 15; bit_cnt stops at 15; neither wraps to 0.
